// File: rtl/seq_detect_param_if.sv
// Serial stream, configuration and status bundle for seq_detect_param.
// master = stream/config source, slave = detector.
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in, cnt_clr,
        input  out, match_cnt
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in, cnt_clr,
        output out, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// Mealy/Moore output selection and a saturating match counter.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter int                 MOORE       = 0,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_0101,
    parameter int                 DEF_LEN     = 3,
    parameter int                 DEF_OVERLAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > MAX_LEN_L) ? MAX_LEN_L : l;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [MAX_LEN-2:0] r_hist_p0;
    logic [LEN_W-1:0]   r_fill_p0;
    logic               r_out_p1;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;
    logic               w_match;
    logic               w_hit;
    logic               w_cnt_evt;
    logic [LEN_W-1:0]   w_fill_next;

    // Window includes the bit arriving this cycle, so a Mealy hit is same-cycle.
    assign w_shift = {r_hist_p0, bus.in};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_fill_ok   = ({1'b0, r_fill_p0} + (LEN_W+1)'(1)) >= {1'b0, r_len};
    assign w_match     = ((w_shift ^ r_pat) & w_mask) == '0;
    assign w_hit       = bus.in_valid && !bus.cfg_load && (r_len != '0) && w_fill_ok && w_match;
    assign w_fill_next = (r_fill_p0 == MAX_LEN_L) ? r_fill_p0 : r_fill_p0 + 1'b1;
    assign w_cnt_evt   = (MOORE != 0) ? r_out_p1 : w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat     <= DEF_PATTERN;
            r_len     <= DEF_LEN_L;
            r_ovl     <= (DEF_OVERLAP != 0);
            r_hist_p0 <= '0;
            r_fill_p0 <= '0;
            r_out_p1  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (bus.cfg_load) begin
                r_pat     <= bus.cfg_pattern;
                r_len     <= clamp_len(bus.cfg_len);
                r_ovl     <= bus.cfg_overlap;
                r_hist_p0 <= '0;
                r_fill_p0 <= '0;
            end else if (bus.in_valid) begin
                r_hist_p0 <= w_shift[MAX_LEN-2:0];
                // Non-overlap mode forgets the consumed bits by emptying the fill level.
                r_fill_p0 <= (w_hit && !r_ovl) ? '0 : w_fill_next;
            end
            // ---- stage p1: registered match for the Moore variant ----
            r_out_p1 <= w_hit;
            if (bus.cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_evt) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end
    end

    assign bus.out       = (MOORE != 0) ? r_out_p1 : w_hit;
    assign bus.match_cnt = r_cnt;
endmodule
